mpmc11_sfifo_fta: RTL and testbench

- Single-clock, parametrised FIFO for mpmc11 request and response queues where the producer and consumer share one clock domain.
- Generalises the existing async entry FIFO in three ways:
  - data width and depth are parameters;
  - read mode is selectable: first-word-fall-through or standard;
  - it adds a programmable-full flag, overflow/underflow/write-ack flags and a read-side occupancy count.
- Storage is inferred distributed RAM. There is no vendor macro.

---
 rtl/mpmc11_pkg.sv | 10 +
 rtl/mpmc11_dpram_dist.sv | 17 +
 rtl/mpmc11_sfifo_fta.sv | 74 +++++++
 tb/tb_mpmc11_sfifo_fta.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mpmc11_pkg.sv
// mpmc11_pkg: shared mpmc11 types and queue sizing
package mpmc11_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [3:0]  id;
  } mpmc11_fifoe_t;
  localparam int MPMC11_FIFO_DEP = 32;
endpackage

// File: rtl/mpmc11_dpram_dist.sv
// mpmc11_dpram_dist: distributed RAM with one synchronous write port and one asynchronous read port
module mpmc11_dpram_dist #(
  parameter int WID = 64,
  parameter int DEP = 32
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [$clog2(DEP)-1:0] wa,
  input  logic [WID-1:0]         wd,
  input  logic [$clog2(DEP)-1:0] ra,
  output logic [WID-1:0]         rd
);
  logic [WID-1:0] mem [DEP];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/mpmc11_sfifo_fta.sv
// mpmc11_sfifo_fta: single-clock FIFO with FWFT or standard read, status flags and occupancy count
module mpmc11_sfifo_fta
  import mpmc11_pkg::*;
#(
  parameter int WID              = 64,
  parameter int DEP              = MPMC11_FIFO_DEP,
  parameter bit FWFT             = 1'b1,
  parameter int PROG_FULL_THRESH = 27,
  parameter int RST_BUSY_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_fifo,
  input  logic [WID-1:0]       din,
  input  logic                 rd_fifo,
  output logic [WID-1:0]       dout,
  output logic                 v,
  output logic                 full,
  output logic                 almost_full,
  output logic                 prog_full,
  output logic                 empty,
  output logic                 almost_empty,
  output logic                 wr_ack,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 rst_busy,
  output logic [$clog2(DEP):0] cnt
);
  localparam int AW = $clog2(DEP);
  localparam int PW = AW + 1;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [3:0]     bc;
  logic [WID-1:0] rd_data, dout_q;
  logic           v_q, wr_ok, rd_ok;
  assign rst_busy     = bc != 4'd0;
  assign empty        = wr_ptr == rd_ptr;
  assign full         = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
  assign cnt          = wr_ptr - rd_ptr;
  assign almost_full  = cnt >= PW'(DEP - 1);
  assign prog_full    = cnt >= PW'(PROG_FULL_THRESH);
  assign almost_empty = cnt <= PW'(1);
  assign wr_ok        = wr_fifo & ~full & ~rst_busy;
  assign rd_ok        = rd_fifo & ~empty & ~rst_busy;
  assign dout         = FWFT ? (empty ? '0 : rd_data) : dout_q;
  assign v            = FWFT ? ~empty : v_q;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      bc        <= 4'(RST_BUSY_CYCLES);
      dout_q    <= '0;
      v_q       <= 1'b0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      bc        <= rst_busy ? bc - 4'd1 : bc;
      wr_ptr    <= wr_ok ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr    <= rd_ok ? rd_ptr + PW'(1) : rd_ptr;
      dout_q    <= rd_ok ? rd_data : dout_q;
      v_q       <= rd_ok;
      wr_ack    <= wr_ok;
      overflow  <= wr_fifo & full & ~rst_busy;
      underflow <= rd_fifo & empty & ~rst_busy;
    end
  mpmc11_dpram_dist #(.WID(WID), .DEP(DEP)) u_ram (
    .clk (clk),
    .we  (wr_ok),
    .wa  (wr_ptr[AW-1:0]),
    .wd  (din),
    .ra  (rd_ptr[AW-1:0]),
    .rd  (rd_data)
  );
endmodule

// File: tb/tb_mpmc11_sfifo_fta.sv
// tb_mpmc11_sfifo_fta: directed checks of the FIFO in FWFT and standard read modes
module tb_mpmc11_sfifo_fta;
  logic clk = 1'b0, rst = 1'b1;
  logic wr_fifo = 1'b0, rd_fifo = 1'b0, wr_s = 1'b0, rd_s = 1'b0;
  logic [63:0] din = '0, din_s = '0, dout, dout_s;
  logic v, full, almost_full, prog_full, empty, almost_empty, wr_ack, overflow, underflow, rst_busy;
  logic v_s, full_s, afull_s, pfull_s, empty_s, aempty_s, wr_ack_s, ovf_s, udf_s, busy_s;
  logic [5:0] cnt, cnt_s;
  int checks = 0, failures = 0;
  logic [63:0] sb [$];
  always #5 clk = ~clk;
  mpmc11_sfifo_fta #(.WID(64), .DEP(32), .FWFT(1'b1), .PROG_FULL_THRESH(27), .RST_BUSY_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .wr_fifo(wr_fifo), .din(din), .rd_fifo(rd_fifo), .dout(dout), .v(v),
    .full(full), .almost_full(almost_full), .prog_full(prog_full), .empty(empty),
    .almost_empty(almost_empty), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .rst_busy(rst_busy), .cnt(cnt)
  );
  mpmc11_sfifo_fta #(.WID(64), .DEP(32), .FWFT(1'b0), .PROG_FULL_THRESH(27), .RST_BUSY_CYCLES(4)) dut_s (
    .clk(clk), .rst(rst), .wr_fifo(wr_s), .din(din_s), .rd_fifo(rd_s), .dout(dout_s), .v(v_s),
    .full(full_s), .almost_full(afull_s), .prog_full(pfull_s), .empty(empty_s),
    .almost_empty(aempty_s), .wr_ack(wr_ack_s), .overflow(ovf_s), .underflow(udf_s),
    .rst_busy(busy_s), .cnt(cnt_s)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    wr_fifo = 1'b1;
    din = 64'h55;
    tick();
    if ({empty, almost_empty, rst_busy} !== 3'b111) begin failures++; $display("FAIL reset_set got=%b exp=111", {empty, almost_empty, rst_busy}); end
    checks++;
    if ({full, almost_full, prog_full, v, wr_ack, overflow, underflow} !== 7'b0) begin failures++; $display("FAIL reset_clr got=%b exp=0000000", {full, almost_full, prog_full, v, wr_ack, overflow, underflow}); end
    checks++;
    if (cnt !== 6'd0 || dout !== 64'd0 || dout_s !== 64'd0 || v_s !== 1'b0) begin failures++; $display("FAIL reset_data cnt=%0d dout=%h dout_s=%h v_s=%b exp 0", cnt, dout, dout_s, v_s); end
    checks++;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rst_busy !== 1'b1 || cnt !== 6'd0 || empty !== 1'b1 || wr_ack !== 1'b0) begin failures++; $display("FAIL busy_hold i=%0d busy=%b cnt=%0d empty=%b wr_ack=%b exp 1/0/1/0", i, rst_busy, cnt, empty, wr_ack); end
      checks++;
      tick();
    end
    wr_fifo = 1'b0;
    if (rst_busy !== 1'b0 || cnt !== 6'd0 || wr_ack !== 1'b0 || busy_s !== 1'b0) begin failures++; $display("FAIL busy_drop busy=%b cnt=%0d wr_ack=%b busy_s=%b exp 0/0/0/0", rst_busy, cnt, wr_ack, busy_s); end
    checks++;
  endtask
  task automatic test_fill();
    logic [4:0] exp;
    int n;
    for (int i = 0; i < 33; i++) begin
      wr_fifo = 1'b1;
      din = 64'(i);
      tick();
      n = i < 32 ? i + 1 : 32;
      exp = {n >= 27, n >= 31, n == 32, i < 32, i == 32};
      if (cnt !== 6'(n)) begin failures++; $display("FAIL fill_cnt i=%0d got=%0d exp=%0d", i, cnt, n); end
      checks++;
      if ({prog_full, almost_full, full, wr_ack, overflow} !== exp) begin failures++; $display("FAIL fill_flags i=%0d got=%b exp=%b", i, {prog_full, almost_full, full, wr_ack, overflow}, exp); end
      checks++;
      if (v !== 1'b1 || dout !== 64'd0) begin failures++; $display("FAIL fill_head i=%0d v=%b dout=%h exp 1/0", i, v, dout); end
      checks++;
    end
    wr_fifo = 1'b0;
    tick();
    if (overflow !== 1'b0 || wr_ack !== 1'b0 || cnt !== 6'd32) begin failures++; $display("FAIL fill_idle ovf=%b ack=%b cnt=%0d exp 0/0/32", overflow, wr_ack, cnt); end
    checks++;
  endtask
  task automatic test_drain();
    for (int i = 0; i < 32; i++) begin
      if (dout !== 64'(i) || v !== 1'b1) begin failures++; $display("FAIL drain_data i=%0d dout=%h v=%b exp %h/1", i, dout, v, 64'(i)); end
      checks++;
      rd_fifo = 1'b1;
      tick();
      if (cnt !== 6'(31 - i) || almost_empty !== (31 - i <= 1) || empty !== (i == 31) || underflow !== 1'b0) begin failures++; $display("FAIL drain_flags i=%0d cnt=%0d ae=%b e=%b udf=%b", i, cnt, almost_empty, empty, underflow); end
      checks++;
    end
    if (v !== 1'b0) begin failures++; $display("FAIL drain_v got=%b exp=0", v); end
    checks++;
    tick();
    if (underflow !== 1'b1 || cnt !== 6'd0) begin failures++; $display("FAIL drain_udf udf=%b cnt=%0d exp 1/0", underflow, cnt); end
    checks++;
    rd_fifo = 1'b0;
    tick();
    if (underflow !== 1'b0) begin failures++; $display("FAIL drain_udf_clr got=%b exp=0", underflow); end
    checks++;
  endtask
  task automatic test_std();
    wr_s = 1'b1;
    din_s = 64'hA5;
    tick();
    din_s = 64'h5A;
    tick();
    wr_s = 1'b0;
    if (v_s !== 1'b0 || cnt_s !== 6'd2 || dout_s !== 64'd0) begin failures++; $display("FAIL std_pre v=%b cnt=%0d dout=%h exp 0/2/0", v_s, cnt_s, dout_s); end
    checks++;
    rd_s = 1'b1;
    tick();
    if (dout_s !== 64'hA5 || v_s !== 1'b1) begin failures++; $display("FAIL std_rd1 dout=%h v=%b exp a5/1", dout_s, v_s); end
    checks++;
    tick();
    rd_s = 1'b0;
    if (dout_s !== 64'h5A || v_s !== 1'b1) begin failures++; $display("FAIL std_rd2 dout=%h v=%b exp 5a/1", dout_s, v_s); end
    checks++;
    tick();
    if (dout_s !== 64'h5A || v_s !== 1'b0 || empty_s !== 1'b1) begin failures++; $display("FAIL std_hold dout=%h v=%b e=%b exp 5a/0/1", dout_s, v_s, empty_s); end
    checks++;
    tick();
    if (dout_s !== 64'h5A || v_s !== 1'b0) begin failures++; $display("FAIL std_hold2 dout=%h v=%b exp 5a/0", dout_s, v_s); end
    checks++;
  endtask
  task automatic test_simul();
    wr_fifo = 1'b1;
    rd_fifo = 1'b1;
    din = 64'h100;
    tick();
    sb.push_back(64'h100);
    rd_fifo = 1'b0;
    if (cnt !== 6'd1 || underflow !== 1'b1 || wr_ack !== 1'b1) begin failures++; $display("FAIL simul_empty cnt=%0d udf=%b ack=%b exp 1/1/1", cnt, underflow, wr_ack); end
    checks++;
    for (int k = 1; k < 32; k++) begin
      din = 64'h100 + 64'(k);
      tick();
      sb.push_back(din);
    end
    if (cnt !== 6'd32 || full !== 1'b1) begin failures++; $display("FAIL simul_fill cnt=%0d full=%b exp 32/1", cnt, full); end
    checks++;
    rd_fifo = 1'b1;
    din = 64'h300;
    if (dout !== sb[0]) begin failures++; $display("FAIL simul_full_head got=%h exp=%h", dout, sb[0]); end
    checks++;
    tick();
    void'(sb.pop_front());
    if (cnt !== 6'd31 || overflow !== 1'b1 || wr_ack !== 1'b0 || dout !== sb[0]) begin failures++; $display("FAIL simul_full cnt=%0d ovf=%b ack=%b dout=%h exp 31/1/0/%h", cnt, overflow, wr_ack, dout, sb[0]); end
    checks++;
    wr_fifo = 1'b0;
    for (int k = 0; k < 21; k++) begin
      if (dout !== sb[0]) begin failures++; $display("FAIL simul_trim k=%0d got=%h exp=%h", k, dout, sb[0]); end
      checks++;
      tick();
      void'(sb.pop_front());
    end
    if (cnt !== 6'd10) begin failures++; $display("FAIL simul_trim_cnt got=%0d exp=10", cnt); end
    checks++;
    wr_fifo = 1'b1;
    for (int k = 0; k < 100; k++) begin
      din = 64'h200 + 64'(k);
      if (dout !== sb[0]) begin failures++; $display("FAIL simul_stream k=%0d got=%h exp=%h", k, dout, sb[0]); end
      checks++;
      tick();
      void'(sb.pop_front());
      sb.push_back(din);
      if (cnt !== 6'd10) begin failures++; $display("FAIL simul_stream_cnt k=%0d got=%0d exp=10", k, cnt); end
      checks++;
    end
    rd_fifo = 1'b0;
    wr_fifo = 1'b0;
  endtask
  task automatic test_mid_reset();
    wr_fifo = 1'b1;
    for (int k = 0; k < 7; k++) begin
      din = 64'h400 + 64'(k);
      tick();
    end
    wr_fifo = 1'b0;
    if (cnt !== 6'd17) begin failures++; $display("FAIL mid_pre cnt=%0d exp=17", cnt); end
    checks++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    if (cnt !== 6'd0 || empty !== 1'b1 || v !== 1'b0 || rst_busy !== 1'b1) begin failures++; $display("FAIL mid_rst cnt=%0d e=%b v=%b busy=%b exp 0/1/0/1", cnt, empty, v, rst_busy); end
    checks++;
    for (int k = 0; k < 4; k++) tick();
    if (rst_busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", rst_busy); end
    checks++;
    wr_fifo = 1'b1;
    din = 64'hBEEF;
    tick();
    din = 64'hCAFE;
    tick();
    wr_fifo = 1'b0;
    if (cnt !== 6'd2 || dout !== 64'hBEEF || v !== 1'b1) begin failures++; $display("FAIL mid_new cnt=%0d dout=%h v=%b exp 2/beef/1", cnt, dout, v); end
    checks++;
    rd_fifo = 1'b1;
    tick();
    if (dout !== 64'hCAFE || cnt !== 6'd1) begin failures++; $display("FAIL mid_rd1 dout=%h cnt=%0d exp cafe/1", dout, cnt); end
    checks++;
    tick();
    rd_fifo = 1'b0;
    if (empty !== 1'b1 || v !== 1'b0) begin failures++; $display("FAIL mid_rd2 e=%b v=%b exp 1/0", empty, v); end
    checks++;
  endtask
  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_std();
    test_simul();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
